axi_rt_budget_bank: RTL and testbench
=====================================

Name: axi_rt_budget_bank

Overview:
Multi-port, multi-region budget/period accounting bank for the RT unit. It replaces the per-region single-debit counter pair with one bank. Each region has a per-region replenish mode (reload, carry-over, one-shot) and an overrun counter, and the bank accepts simultaneous debits from several AX probe ports. It sits after the write buffer/splitter, fed by AW/AR handshake probes and address-decode indices, and drives the isolate request.

Parameters:
NumRegions, 4, number of address regions tracked
NumPorts, 2, number of debit ports (e.g. AW and AR of shared budget, or several managers)
PeriodWidth, 32, period counter width
BudgetWidth, 32, budget counter width
BytesWidth, 16, width of one debit amount
OvrWidth, 8, per-region overrun counter width
RegionIdxWidth, idx_width(NumRegions), derived

Ports:
clk_i  in  1  clock
rst_ni  in  1  async reset, active low
enable_i  in  1  global bank enable
abort_i  in  NumRegions  per-region period abort/restart
debit_valid_i  in  NumPorts  debit strobe (AX handshake happened)
debit_region_i  in  NumPorts*RegionIdxWidth  target region per port
debit_bytes_i  in  NumPorts*BytesWidth  bytes to debit per port
mode_i  in  NumRegions*2  replenish mode per region (axi_rt_pkg::rt_mode_e)
budget_i  in  NumRegions*BudgetWidth  budget per period
budget_cap_i  in  NumRegions*BudgetWidth  carry-over ceiling
period_i  in  NumRegions*PeriodWidth  period length in cycles
budget_left_o  out  NumRegions*BudgetWidth  remaining budget
period_left_o  out  NumRegions*PeriodWidth  remaining period
depleted_o  out  NumRegions  region out of budget
overrun_cnt_o  out  NumRegions*OvrWidth  saturating overrun count
isolate_o  out  1  OR of depleted_o, gated by enable_i

Behaviour:
- Reset: all counters 0, state IDLE, depleted_o=0, overrun_cnt_o=0, isolate_o=0.
- Per-region FSM: IDLE, RUN, DEPLETED.
- IDLE: entered when enable_i=0, from any state. Counters hold. On the first cycle with enable_i=1: load period_left=period_i, budget_left=budget_i, go RUN.
- RUN: period_left decrements by 1 per cycle. Sum all valid debits whose debit_region_i equals this region. Operand width BudgetWidth+clog2(NumPorts)+1, bytes zero-extended.
  - If sum < budget_left: subtract.
  - If sum == budget_left: left=0, go DEPLETED.
  - If sum > budget_left: left=0, overrun_cnt+1 (saturating), go DEPLETED.
- DEPLETED: debits ignored, no further overrun counting. period_left keeps decrementing.
- Period end (period_left==0 in RUN or DEPLETED), next cycle:
  - period_left reloads to period_i; state goes RUN.
  - budget_left by mode:
    - RELOAD (0): budget_i.
    - CARRY (1): min(budget_left+budget_i, budget_cap_i), computed at width BudgetWidth+1.
    - ONESHOT (2): unchanged; DEPLETED persists until abort_i.
    - Mode 3: treated as RELOAD.
  - Debits in the reload cycle are dropped.
- abort_i[r] (enable_i=1): next cycle reload period and budget_i, state RUN, overrun_cnt unchanged. abort_i beats period end and debits in the same cycle.
- period_i==0: region reloads every cycle. It never depletes except through a same-cycle debit ≥ budget_i.
- budget_i==0: region enters DEPLETED on the load cycle.
- Latency: debit in cycle t is visible in budget_left_o/depleted_o at t+1. isolate_o is combinational from depleted_o & enable_i.
- Dropping enable_i mid-operation: state IDLE next cycle, depleted_o=0, counters frozen. Re-enable performs a fresh load.
- Config inputs are sampled only at load; changes mid-period have no effect until the next load.

Optional Feature:
AXI_RT_BUDGET_STATS_EN:
- Defined: adds output total_bytes_o (NumRegions*48). It is a wrapping per-region sum of all accepted debit bytes, including the partial amount consumed on overrun (the pre-debit budget_left). It is cleared only by reset.
- Undefined: port and logic absent; overrun_cnt_o still present.

Decomposition:
- axi_rt_pkg holds:
  - rt_mode_e (RELOAD, CARRY, ONESHOT, 2 bits);
  - rt_budget_state_e (IDLE, RUN, DEPLETED);
  - stats width constant 48.
- Sub-module axi_rt_budget_region: one region's FSM, counters and mode logic, with a pre-summed debit input. The top does per-region port summing via a generate loop and instantiates NumRegions copies.

Test Plan:
- RELOAD, budget=64, period=10, port0 debits 16 in cycles 1–4 → depleted_o rises at cycle 5; at period end budget_left=64, depleted_o=0, overrun_cnt=0.
- Both ports debit region 2 in the same cycle (40+40), budget=64 → budget_left=0, depleted_o=1, overrun_cnt=1 next cycle; other regions unchanged.
- CARRY, budget=32, cap=80, no debits for 3 periods → budget_left goes 32→64→80→80.
- ONESHOT, budget=8, debit 8 → depleted through 3 period ends; abort_i pulse → budget_left=8, RUN next cycle.
- abort_i in the same cycle as period end and a debit of 4 → budget_left=budget_i, period_left=period_i, no debit applied.
- enable_i dropped while DEPLETED → depleted_o=0, isolate_o=0 next cycle; re-enable reloads budget_i/period_i; reset mid-run → all outputs 0.

Source files
------------

// File: rtl/axi_rt_pkg.sv
// Shared types for the RT budget bank: replenish modes, region states,
// statistics width and the region index width helper.
package axi_rt_pkg;

  typedef enum logic [1:0] {
    RT_RELOAD  = 2'd0,
    RT_CARRY   = 2'd1,
    RT_ONESHOT = 2'd2
  } rt_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_DEPLETED = 2'd2
  } rt_budget_state_e;

  localparam int unsigned StatsWidth = 48;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_rt_budget_region.sv
// One budget/period region: FSM, counters, replenish mode, overrun count.
// Optional AXI_RT_BUDGET_STATS_EN adds a wrapping accepted-bytes total.
module axi_rt_budget_region
  import axi_rt_pkg::*;
#(
  parameter int unsigned PeriodWidth = 32,
  parameter int unsigned BudgetWidth = 32,
  parameter int unsigned OvrWidth    = 8,
  parameter int unsigned SumWidth    = 34
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   enable_i,
  input  logic                   abort_i,
  input  logic [SumWidth-1:0]    debit_i,
  input  logic [1:0]             mode_i,
  input  logic [BudgetWidth-1:0] budget_i,
  input  logic [BudgetWidth-1:0] budget_cap_i,
  input  logic [PeriodWidth-1:0] period_i,
  output logic [BudgetWidth-1:0] budget_left_o,
  output logic [PeriodWidth-1:0] period_left_o,
  output logic                   depleted_o,
`ifdef AXI_RT_BUDGET_STATS_EN
  output logic [StatsWidth-1:0]  total_bytes_o,
`endif
  output logic [OvrWidth-1:0]    overrun_cnt_o
);

  rt_budget_state_e state_q, state_d;
  logic [BudgetWidth-1:0] budget_q, budget_d;
  logic [PeriodWidth-1:0] period_q, period_d;
  logic [OvrWidth-1:0]    ovr_q, ovr_d;

  logic [BudgetWidth:0]   carry;
  logic [BudgetWidth-1:0] capped;
  logic [BudgetWidth-1:0] base;
  logic [BudgetWidth-1:0] left;
  logic [SumWidth-1:0]    left_ext;
  logic                   apply;

  assign carry    = {1'b0, budget_q} + {1'b0, budget_i};
  assign capped   = (carry > {1'b0, budget_cap_i}) ? budget_cap_i
                                                   : carry[BudgetWidth-1:0];
  assign left_ext = SumWidth'(left);

  always_comb begin
    base = budget_i;
    case (mode_i)
      RT_CARRY:   base = capped;
      RT_ONESHOT: base = budget_q;
      default:    base = budget_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    budget_d = budget_q;
    period_d = period_q;
    ovr_d    = ovr_q;
    apply    = 1'b0;
    left     = budget_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_IDLE || abort_i) begin
      period_d = period_i;
      budget_d = budget_i;
      state_d  = (budget_i == '0) ? ST_DEPLETED : ST_RUN;
    end else if (period_q == '0) begin
      period_d = period_i;
      if (mode_i != RT_ONESHOT) begin
        budget_d = base;
        left     = base;
        state_d  = (base == '0) ? ST_DEPLETED : ST_RUN;
        // zero-length period: every cycle reloads, so debit the fresh budget
        apply    = (period_i == '0);
      end
    end else begin
      period_d = period_q - PeriodWidth'(1);
      apply    = (state_q == ST_RUN);
    end
    if (apply) begin
      if (debit_i < left_ext) begin
        budget_d = left - debit_i[BudgetWidth-1:0];
      end else begin
        budget_d = '0;
        state_d  = ST_DEPLETED;
        if (debit_i > left_ext && ovr_q != '1)
          ovr_d = ovr_q + OvrWidth'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      budget_q <= '0;
      period_q <= '0;
      ovr_q    <= '0;
    end else begin
      state_q  <= state_d;
      budget_q <= budget_d;
      period_q <= period_d;
      ovr_q    <= ovr_d;
    end
  end

`ifdef AXI_RT_BUDGET_STATS_EN
  logic [SumWidth-1:0]   accepted;
  logic [StatsWidth-1:0] total_q;

  always_comb begin
    accepted = '0;
    if (apply)
      accepted = (debit_i < left_ext) ? debit_i : left_ext;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) total_q <= '0;
    else         total_q <= total_q + StatsWidth'(accepted);
  end

  assign total_bytes_o = total_q;
`endif

  assign budget_left_o = budget_q;
  assign period_left_o = period_q;
  assign depleted_o    = (state_q == ST_DEPLETED);
  assign overrun_cnt_o = ovr_q;

endmodule

// File: rtl/axi_rt_budget_bank.sv
// Multi-port, multi-region RT budget bank; sums port debits per region.
// Optional AXI_RT_BUDGET_STATS_EN exposes per-region accepted-byte totals.
module axi_rt_budget_bank
  import axi_rt_pkg::*;
#(
  parameter int unsigned NumRegions     = 4,
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned PeriodWidth    = 32,
  parameter int unsigned BudgetWidth    = 32,
  parameter int unsigned BytesWidth     = 16,
  parameter int unsigned OvrWidth       = 8,
  parameter int unsigned RegionIdxWidth = idx_width(NumRegions)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              enable_i,
  input  logic [NumRegions-1:0]             abort_i,
  input  logic [NumPorts-1:0]               debit_valid_i,
  input  logic [NumPorts*RegionIdxWidth-1:0] debit_region_i,
  input  logic [NumPorts*BytesWidth-1:0]    debit_bytes_i,
  input  logic [NumRegions*2-1:0]           mode_i,
  input  logic [NumRegions*BudgetWidth-1:0] budget_i,
  input  logic [NumRegions*BudgetWidth-1:0] budget_cap_i,
  input  logic [NumRegions*PeriodWidth-1:0] period_i,
  output logic [NumRegions*BudgetWidth-1:0] budget_left_o,
  output logic [NumRegions*PeriodWidth-1:0] period_left_o,
  output logic [NumRegions-1:0]             depleted_o,
  output logic [NumRegions*OvrWidth-1:0]    overrun_cnt_o,
`ifdef AXI_RT_BUDGET_STATS_EN
  output logic [NumRegions*StatsWidth-1:0]  total_bytes_o,
`endif
  output logic                              isolate_o
);

  localparam int unsigned SumWidth = BudgetWidth + $clog2(NumPorts) + 1;

  for (genvar r = 0; r < NumRegions; r++) begin : g_region
    logic [SumWidth-1:0] sum;

    always_comb begin
      sum = '0;
      for (int p = 0; p < NumPorts; p++) begin
        if (debit_valid_i[p] &&
            debit_region_i[p*RegionIdxWidth +: RegionIdxWidth] ==
              RegionIdxWidth'(r))
          sum = sum + SumWidth'(debit_bytes_i[p*BytesWidth +: BytesWidth]);
      end
    end

    axi_rt_budget_region #(
      .PeriodWidth (PeriodWidth),
      .BudgetWidth (BudgetWidth),
      .OvrWidth    (OvrWidth),
      .SumWidth    (SumWidth)
    ) u_region (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .abort_i       (abort_i[r]),
      .debit_i       (sum),
      .mode_i        (mode_i[r*2 +: 2]),
      .budget_i      (budget_i[r*BudgetWidth +: BudgetWidth]),
      .budget_cap_i  (budget_cap_i[r*BudgetWidth +: BudgetWidth]),
      .period_i      (period_i[r*PeriodWidth +: PeriodWidth]),
      .budget_left_o (budget_left_o[r*BudgetWidth +: BudgetWidth]),
      .period_left_o (period_left_o[r*PeriodWidth +: PeriodWidth]),
      .depleted_o    (depleted_o[r]),
`ifdef AXI_RT_BUDGET_STATS_EN
      .total_bytes_o (total_bytes_o[r*StatsWidth +: StatsWidth]),
`endif
      .overrun_cnt_o (overrun_cnt_o[r*OvrWidth +: OvrWidth])
    );
  end

  assign isolate_o = enable_i & (|depleted_o);

endmodule

// File: tb/tb_axi_rt_budget_bank.sv
// Directed bench for axi_rt_budget_bank: reload, overrun, carry, one-shot,
// abort priority, enable drop and async reset, with hand-computed values.
module tb_axi_rt_budget_bank;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [3:0]   abort;
  logic [1:0]   dv;
  logic [3:0]   dreg_v;
  logic [31:0]  dby_v;
  logic [7:0]   mode_v;
  logic [127:0] bud_v;
  logic [127:0] cap_v;
  logic [127:0] per_v;
  logic [127:0] budget_left;
  logic [127:0] period_left;
  logic [3:0]   depleted;
  logic [31:0]  overrun;
  logic         isolate;
`ifdef AXI_RT_BUDGET_STATS_EN
  logic [191:0] total_bytes;
`endif

  logic [1:0]  mode [4];
  logic [31:0] bud  [4];
  logic [31:0] cap  [4];
  logic [31:0] per  [4];
  logic [1:0]  dreg [2];
  logic [15:0] dby  [2];

  int n_cmp = 0;
  int n_err = 0;

  always_comb begin
    mode_v = '0;
    bud_v  = '0;
    cap_v  = '0;
    per_v  = '0;
    dreg_v = '0;
    dby_v  = '0;
    for (int r = 0; r < 4; r++) begin
      mode_v[r*2 +: 2]  = mode[r];
      bud_v[r*32 +: 32] = bud[r];
      cap_v[r*32 +: 32] = cap[r];
      per_v[r*32 +: 32] = per[r];
    end
    for (int p = 0; p < 2; p++) begin
      dreg_v[p*2 +: 2]  = dreg[p];
      dby_v[p*16 +: 16] = dby[p];
    end
  end

  axi_rt_budget_bank dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .enable_i       (enable),
    .abort_i        (abort),
    .debit_valid_i  (dv),
    .debit_region_i (dreg_v),
    .debit_bytes_i  (dby_v),
    .mode_i         (mode_v),
    .budget_i       (bud_v),
    .budget_cap_i   (cap_v),
    .period_i       (per_v),
    .budget_left_o  (budget_left),
    .period_left_o  (period_left),
    .depleted_o     (depleted),
    .overrun_cnt_o  (overrun),
`ifdef AXI_RT_BUDGET_STATS_EN
    .total_bytes_o  (total_bytes),
`endif
    .isolate_o      (isolate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] bl(input int r);
    return budget_left[r*32 +: 32];
  endfunction

  function automatic logic [31:0] pl(input int r);
    return period_left[r*32 +: 32];
  endfunction

  function automatic logic [7:0] ov(input int r);
    return overrun[r*8 +: 8];
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic debit(input int p, input logic [1:0] r,
                       input logic [15:0] b);
    dv[p]   = 1'b1;
    dreg[p] = r;
    dby[p]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dv    = '0;
    abort = '0;
  endtask

  initial begin
    rst_n  = 1'b0;
    enable = 1'b0;
    abort  = '0;
    dv     = '0;
    for (int p = 0; p < 2; p++) begin
      dreg[p] = '0;
      dby[p]  = '0;
    end
    mode[0] = 2'd0; bud[0] = 32'd64; cap[0] = 32'd0;  per[0] = 32'd10;
    mode[1] = 2'd1; bud[1] = 32'd32; cap[1] = 32'd80; per[1] = 32'd3;
    mode[2] = 2'd0; bud[2] = 32'd64; cap[2] = 32'd0;  per[2] = 32'd100;
    mode[3] = 2'd2; bud[3] = 32'd8;  cap[3] = 32'd0;  per[3] = 32'd2;

    #3;
    chk("rst_budget",   budget_left, 128'd0);
    chk("rst_period",   period_left, 128'd0);
    chk("rst_depleted", depleted, 128'd0);
    chk("rst_overrun",  overrun, 128'd0);
    chk("rst_isolate",  isolate, 128'd0);

    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    tick();
    chk("k0_b0", bl(0), 64);
    chk("k0_p0", pl(0), 10);
    chk("k0_b1", bl(1), 32);
    chk("k0_p3", pl(3), 2);
    chk("k0_dep", depleted, 0);

    debit(0, 2'd0, 16'd16);
    debit(1, 2'd3, 16'd8);
    tick();
    chk("k1_b0", bl(0), 48);
    chk("k1_b3", bl(3), 0);
    chk("k1_dep3", depleted[3], 1);
    chk("k1_ovr3", ov(3), 0);

    debit(0, 2'd0, 16'd16);
    tick();
    debit(0, 2'd0, 16'd16);
    tick();
    chk("k3_b0", bl(0), 16);
    chk("k3_dep0", depleted[0], 0);
    chk("k3_b1", bl(1), 32);

    debit(0, 2'd0, 16'd16);
    tick();
    chk("k4_b0", bl(0), 0);
    chk("k4_dep0", depleted[0], 1);
    chk("k4_iso", isolate, 1);
    chk("k4_p0", pl(0), 6);
    chk("k4_b1_carry", bl(1), 64);

    debit(0, 2'd2, 16'd40);
    debit(1, 2'd2, 16'd40);
    tick();
    chk("k5_b2", bl(2), 0);
    chk("k5_dep2", depleted[2], 1);
    chk("k5_ovr2", ov(2), 1);
    chk("k5_ovr0", ov(0), 0);
    chk("k5_b0", bl(0), 0);
    chk("k5_b1", bl(1), 64);

    repeat (3) tick();
    chk("k8_b1_carry", bl(1), 80);
    chk("k8_p0", pl(0), 2);

    tick();
    chk("k9_dep3", depleted[3], 1);
    chk("k9_b3", bl(3), 0);

    abort[3] = 1'b1;
    tick();
    chk("k10_b3", bl(3), 8);
    chk("k10_p3", pl(3), 2);
    chk("k10_dep3", depleted[3], 0);
    chk("k10_dep0", depleted[0], 1);

    tick();
    chk("k11_b0", bl(0), 64);
    chk("k11_p0", pl(0), 10);
    chk("k11_dep0", depleted[0], 0);
    chk("k11_ovr0", ov(0), 0);

    bud[0] = 32'd50;
    per[0] = 32'd7;
    tick();
    chk("k12_b0_held", bl(0), 64);
    chk("k12_p0_held", pl(0), 9);
    chk("k12_b1_cap", bl(1), 80);

    repeat (9) tick();
    chk("k21_p0", pl(0), 0);
    abort[0] = 1'b1;
    debit(0, 2'd0, 16'd4);
    tick();
    chk("k22_b0", bl(0), 50);
    chk("k22_p0", pl(0), 7);

    tick();
    abort[0] = 1'b1;
    debit(0, 2'd0, 16'd4);
    tick();
    chk("k24_b0", bl(0), 50);
    chk("k24_p0", pl(0), 7);

    enable = 1'b0;
    tick();
    chk("k25_dep", depleted, 0);
    chk("k25_iso", isolate, 0);
    chk("k25_b2", bl(2), 0);
    chk("k25_p2", pl(2), 76);
    chk("k25_ovr2", ov(2), 1);

    bud[2] = 32'd20;
    per[2] = 32'd5;
    enable = 1'b1;
    tick();
    chk("k26_b2", bl(2), 20);
    chk("k26_p2", pl(2), 5);
    chk("k26_dep2", depleted[2], 0);
    chk("k26_ovr2", ov(2), 1);

    #2;
    rst_n = 1'b0;
    #2;
    chk("mrst_budget",   budget_left, 128'd0);
    chk("mrst_period",   period_left, 128'd0);
    chk("mrst_depleted", depleted, 128'd0);
    chk("mrst_overrun",  overrun, 128'd0);
    chk("mrst_isolate",  isolate, 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
